axi_usb_burst_decoder: RTL and testbench
========================================

Name: axi_usb_burst_decoder

Overview:
- Parametrised successor to the single-beat AXI-side address decoder of the USB 2.0 host controller.
- Accepts one AXI-style request per handshake (address, direction, size, length, burst type) and walks it beat by beat.
- Each beat produces registered byte-lane enables for the packet buffer memory, or a read/write strobe for the register file.
- Flags misaligned, oversized and out-of-map beats as decode errors and keeps a saturating error count.

Parameters:
- ADDR_W, 32: request address width.
- DATA_W, 32: data bus width; must be 32, 64 or 128. STRB = DATA_W/8 lanes, L = log2(STRB).
- MEM_AW, 6: memory word-address width.
- REG_AW, 6: register byte-address width.
- SEL_BIT, 8: address bit selecting the region: 0 = memory, 1 = registers.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  decoder idle, can accept a request
- req_write  in  1  1 = bus-to-USB write, 0 = USB-to-bus read
- req_addr  in  ADDR_W  start byte address
- req_size  in  3  bytes per beat = 2^req_size
- req_len  in  8  beats minus 1
- req_burst  in  1  0 = FIXED, 1 = INCR
- beat_ready  in  1  downstream can take a beat this edge
- beat_valid  out  1  beat outputs valid this cycle
- beat_last  out  1  final beat of the burst
- mem_we  out  STRB  memory byte-lane write enables
- mem_re  out  STRB  memory byte-lane read enables
- mem_addr  out  MEM_AW  memory word address
- reg_we  out  1  register write strobe
- reg_re  out  1  register read strobe
- reg_addr  out  REG_AW  register byte address
- dec_err  out  1  current beat failed to decode
- err_cnt  out  8  saturating count of error beats

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; err_cnt=0. Applies immediately and discards any burst in progress.
- States:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch the request and reset the beat counter, then go to BURST. No beat is issued in that cycle.
  - BURST: req_ready=0. On each edge with beat_ready=1, register one beat: beat_valid=1 for exactly one cycle, with enables per the decode rules below. On edges with beat_ready=0, beat_valid and all enables are 0 and the address and counter hold.
  - After the edge that registers beat req_len, assert beat_last with that beat and return to IDLE.
- Latency: the first beat is valid at the earliest 2 edges after acceptance. A new request is accepted at the earliest on the edge after the last beat.
- Beat address: beat 0 uses req_addr.
  - INCR: each next beat adds 2^req_size, computed modulo 2^ADDR_W.
  - FIXED: the address is constant.
- Decode per beat, in this priority order:
  - req_size > L → dec_err.
  - Address not aligned to 2^req_size → dec_err.
  - addr[ADDR_W-1:SEL_BIT+1] ≠ 0 → dec_err.
  - Else if addr[SEL_BIT]=0 (memory):
    - mem_addr = addr[MEM_AW+L-1:L].
    - Lane mask = (2^(2^req_size) − 1) << addr[L-1:0].
    - Mask goes to mem_we if writing, mem_re if reading.
    - Memory word addresses wrap modulo 2^MEM_AW within the region.
  - Else (registers):
    - reg_addr = addr[REG_AW-1:0].
    - req_size must be L (full word), otherwise dec_err.
    - Assert reg_we or reg_re.
- Error beat: dec_err=1 with beat_valid, all enables 0, burst continues. err_cnt increments and saturates at 255.
- mem_addr and reg_addr hold their last value when not accessed.
- At most one of mem_we, mem_re, reg_we, reg_re is non-zero in any cycle.
- A region change mid-INCR burst is decoded per beat; no error is raised just for crossing regions.

Test Plan:
- DATA_W=32, write addr 0x005, size 0, len 0, beat_ready=1 → one beat 2 edges after accept: mem_we=0001<<1=0010, mem_addr=1, beat_last=1; req_ready back to 1 the next cycle.
- INCR read addr 0x000, size 2, len 3 → mem_re=1111 on 4 consecutive beats with mem_addr 0,1,2,3; beat_last only on the 4th.
- INCR write addr 0x0FC, size 2, len 1 → beat 0 mem_we=1111, mem_addr=63; beat 1 at 0x100 gives reg_we=1, reg_addr=0.
- Read addr 0x102, size 1 (register, sub-word) → dec_err=1, no enables, err_cnt=1. Misaligned addr 0x003 size 2 → dec_err, err_cnt=2.
- INCR len 3 with beat_ready toggling 1,0,0,1,1,0,1 → beats only on edges where beat_ready=1, address and counter held during stalls, exactly 4 beats.
- Rst=0 after beat 1 of a len-7 burst → next cycle all outputs 0, req_ready=1, err_cnt=0; a new request is accepted normally.

Source files
------------

// File: rtl/axi_usb_burst_decoder.sv
// AXI-side burst decoder for the USB 2.0 host controller: walks one request beat by beat and
// turns each beat into packet-buffer byte-lane enables or a register-file strobe.
module axi_usb_burst_decoder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_AW  = 6,
    parameter int unsigned REG_AW  = 6,
    parameter int unsigned SEL_BIT = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [2:0]             req_size_i,
    input  logic [7:0]             req_len_i,
    input  logic                   req_burst_i,
    input  logic                   beat_ready_i,
    output logic                   beat_valid_o,
    output logic                   beat_last_o,
    output logic [DATA_W/8-1:0]    mem_we_o,
    output logic [DATA_W/8-1:0]    mem_re_o,
    output logic [MEM_AW-1:0]      mem_addr_o,
    output logic                   reg_we_o,
    output logic                   reg_re_o,
    output logic [REG_AW-1:0]      reg_addr_o,
    output logic                   dec_err_o,
    output logic [7:0]             err_cnt_o
);

    localparam int unsigned Strb  = DATA_W / 8;
    localparam int unsigned L     = $clog2(Strb);
    localparam int unsigned MaskW = 2 * Strb;
    localparam logic [2:0]  LSz   = 3'(L);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic                burst_q, burst_d;
    logic                beat_valid_q, beat_valid_d;
    logic                beat_last_q, beat_last_d;
    logic [Strb-1:0]     mem_we_q, mem_we_d;
    logic [Strb-1:0]     mem_re_q, mem_re_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                reg_we_q, reg_we_d;
    logic                reg_re_q, reg_re_d;
    logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
    logic                dec_err_q, dec_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [7:0]          align_mask;
    logic [MaskW-1:0]    lane_mask;
    logic                size_err, misalign, out_of_map, is_reg, beat_err;

    // Beat decode works off the current beat address held in addr_q.
    always_comb begin
        align_mask = (8'd1 << size_q) - 8'd1;
        size_err   = (size_q > LSz);
        misalign   = |(addr_q[7:0] & align_mask);
        out_of_map = |addr_q[ADDR_W-1:SEL_BIT+1];
        is_reg     = addr_q[SEL_BIT];
        beat_err   = size_err || misalign || out_of_map || (is_reg && (size_q != LSz));
        lane_mask  = ((MaskW'(1) << (8'd1 << size_q)) - MaskW'(1)) << addr_q[L-1:0];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        burst_d      = burst_q;
        beat_valid_d = 1'b0;
        beat_last_d  = 1'b0;
        mem_we_d     = '0;
        mem_re_d     = '0;
        mem_addr_d   = mem_addr_q;
        reg_we_d     = 1'b0;
        reg_re_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        dec_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    len_d   = req_len_i;
                    write_d = req_write_i;
                    burst_d = req_burst_i;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (beat_ready_i) begin
                    beat_valid_d = 1'b1;
                    beat_last_d  = (cnt_q == len_q);
                    if (beat_err) begin
                        dec_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else if (!is_reg) begin
                        mem_addr_d = MEM_AW'(addr_q >> L);
                        if (write_q) begin
                            mem_we_d = lane_mask[Strb-1:0];
                        end else begin
                            mem_re_d = lane_mask[Strb-1:0];
                        end
                    end else begin
                        reg_addr_d = addr_q[REG_AW-1:0];
                        reg_we_d   = write_q;
                        reg_re_d   = !write_q;
                    end
                    if (burst_q) begin
                        addr_d = addr_q + (ADDR_W'(1) << size_q);
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            size_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            burst_q      <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            mem_we_q     <= '0;
            mem_re_q     <= '0;
            mem_addr_q   <= '0;
            reg_we_q     <= 1'b0;
            reg_re_q     <= 1'b0;
            reg_addr_q   <= '0;
            dec_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            burst_q      <= burst_d;
            beat_valid_q <= beat_valid_d;
            beat_last_q  <= beat_last_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            reg_we_q     <= reg_we_d;
            reg_re_q     <= reg_re_d;
            reg_addr_q   <= reg_addr_d;
            dec_err_q    <= dec_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign beat_valid_o = beat_valid_q;
    assign beat_last_o  = beat_last_q;
    assign mem_we_o     = mem_we_q;
    assign mem_re_o     = mem_re_q;
    assign mem_addr_o   = mem_addr_q;
    assign reg_we_o     = reg_we_q;
    assign reg_re_o     = reg_re_q;
    assign reg_addr_o   = reg_addr_q;
    assign dec_err_o    = dec_err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_axi_usb_burst_decoder.sv
// Self-checking bench for axi_usb_burst_decoder: directed scenarios plus random bursts,
// each beat compared against a per-beat reference model of the decode rules.
module tb_axi_usb_burst_decoder;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_AW  = 6;
    localparam int REG_AW  = 6;
    localparam int SEL_BIT = 8;
    localparam int STRB    = DATA_W / 8;
    localparam int LG      = 2;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [2:0]        req_size = '0;
    logic [7:0]        req_len = '0;
    logic              req_burst = 1'b0;
    logic              beat_ready = 1'b0;
    logic              beat_valid, beat_last;
    logic [STRB-1:0]   mem_we, mem_re;
    logic [MEM_AW-1:0] mem_addr;
    logic              reg_we, reg_re;
    logic [REG_AW-1:0] reg_addr;
    logic              dec_err;
    logic [7:0]        err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                m_err_cnt = 0;
    logic [MEM_AW-1:0] m_mem_addr = '0;
    logic [REG_AW-1:0] m_reg_addr = '0;
    logic [31:0]       ready_pat = '0;
    int                ready_len = 1;

    always #5 Clk = ~Clk;

    axi_usb_burst_decoder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW),
        .REG_AW (REG_AW),
        .SEL_BIT(SEL_BIT)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_size_i  (req_size),
        .req_len_i   (req_len),
        .req_burst_i (req_burst),
        .beat_ready_i(beat_ready),
        .beat_valid_o(beat_valid),
        .beat_last_o (beat_last),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_addr_o  (mem_addr),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_addr_o  (reg_addr),
        .dec_err_o   (dec_err),
        .err_cnt_o   (err_cnt)
    );

    // Decode one beat straight from the address-map rules.
    function automatic void model_beat(input logic [31:0] a, input int sz, input bit wr,
                                       output bit err, output logic [STRB-1:0] mwe,
                                       output logic [STRB-1:0] mre, output bit rwe,
                                       output bit rre);
        int mask;
        err = 0; mwe = '0; mre = '0; rwe = 0; rre = 0;
        if (sz > LG) err = 1;
        else if ((a % (32'd1 << sz)) != 0) err = 1;
        else if ((a >> (SEL_BIT + 1)) != 0) err = 1;
        else if (((a >> SEL_BIT) & 32'd1) == 0) begin
            m_mem_addr = MEM_AW'((a / STRB) % (1 << MEM_AW));
            mask = ((1 << (1 << sz)) - 1) << (a % STRB);
            if (wr) mwe = STRB'(mask);
            else    mre = STRB'(mask);
        end else if (sz != LG) err = 1;
        else begin
            m_reg_addr = REG_AW'(a % (1 << REG_AW));
            rwe = wr;
            rre = !wr;
        end
        if (err && m_err_cnt < 255) m_err_cnt++;
    endfunction

    // mode: 0 = beat_ready always 1, 1 = ready_pat sequence, 2 = random.
    task automatic run_burst(input bit wr, input logic [31:0] addr, input int sz, input int len,
                             input bit incr, input int mode, input int abort_after,
                             output int beats);
        logic [31:0]     a;
        int              k;
        bit              br, e_err, e_rwe, e_rre, e_last;
        logic [STRB-1:0] e_mwe, e_mre;
        beats = 0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL req_ready_before_accept: got %b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = 3'(sz);
        req_len    = 8'(len);
        req_burst  = incr;
        beat_ready = 1'($urandom % 2);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = 3'($urandom);
        req_len   = 8'($urandom);
        n_checks++;
        if (req_ready !== 1'b0 || beat_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL accept_cycle: req_ready=%b beat_valid=%b want 0 0", req_ready,
                     beat_valid);
        end
        a = addr;
        k = 0;
        for (int cyc = 0; cyc < 1000 && k <= len; cyc++) begin
            case (mode)
                0:       br = 1'b1;
                1:       br = ready_pat[cyc % ready_len];
                default: br = 1'($urandom % 2);
            endcase
            beat_ready = br;
            @(posedge Clk); #1;
            e_err = 0; e_mwe = '0; e_mre = '0; e_rwe = 0; e_rre = 0; e_last = 0;
            if (br) begin
                model_beat(a, sz, wr, e_err, e_mwe, e_mre, e_rwe, e_rre);
                e_last = (k == len);
                if (incr) a = a + (32'd1 << sz);
                k++;
            end
            if (beat_valid === 1'b1) beats++;
            n_checks++;
            if (beat_valid !== br || beat_last !== e_last || dec_err !== e_err ||
                mem_we !== e_mwe || mem_re !== e_mre || reg_we !== e_rwe || reg_re !== e_rre ||
                mem_addr !== m_mem_addr || reg_addr !== m_reg_addr ||
                err_cnt !== 8'(m_err_cnt)) begin
                n_errors++;
                $display({"FAIL beat addr=%h k=%0d: got v=%b l=%b e=%b mwe=%b mre=%b rwe=%b ",
                          "rre=%b ma=%0d ra=%0d cnt=%0d want v=%b l=%b e=%b mwe=%b mre=%b ",
                          "rwe=%b rre=%b ma=%0d ra=%0d cnt=%0d"},
                         a, k, beat_valid, beat_last, dec_err, mem_we, mem_re, reg_we, reg_re,
                         mem_addr, reg_addr, err_cnt, br, e_last, e_err, e_mwe, e_mre, e_rwe,
                         e_rre, m_mem_addr, m_reg_addr, m_err_cnt);
            end
            if (abort_after >= 0 && k > abort_after) return;
        end
        beat_ready = 1'b0;
        n_checks++;
        if (k <= len || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_after_last: beats_done=%0d want %0d req_ready=%b want 1", k,
                     len + 1, req_ready);
        end
    endtask

    task automatic apply_reset_and_check(input string name);
        Rst = 1'b0;
        beat_ready = 1'b1;
        req_valid  = 1'b1;
        @(posedge Clk); #1;
        m_err_cnt = 0; m_mem_addr = '0; m_reg_addr = '0;
        n_checks++;
        if (req_ready !== 1'b1 || beat_valid !== 1'b0 || beat_last !== 1'b0 ||
            mem_we !== '0 || mem_re !== '0 || mem_addr !== '0 || reg_we !== 1'b0 ||
            reg_re !== 1'b0 || reg_addr !== '0 || dec_err !== 1'b0 || err_cnt !== 8'd0) begin
            n_errors++;
            $display({"FAIL %s: got rdy=%b v=%b l=%b mwe=%b mre=%b ma=%0d rwe=%b rre=%b ",
                      "ra=%0d e=%b cnt=%0d want rdy=1 and all others 0"},
                     name, req_ready, beat_valid, beat_last, mem_we, mem_re, mem_addr, reg_we,
                     reg_re, reg_addr, dec_err, err_cnt);
        end
        req_valid  = 1'b0;
        beat_ready = 1'b0;
        Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        apply_reset_and_check("reset_state");
        n_checks++;
        if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: req_ready=%b beat_valid=%b want 1 0", req_ready,
                     beat_valid);
        end
    endtask

    task automatic test_single_write();
        int beats;
        run_burst(1'b1, 32'h005, 0, 0, 1'b1, 0, -1, beats);
        n_checks++;
        if (beats !== 1 || mem_addr !== 6'd1) begin
            n_errors++;
            $display("FAIL single_write: beats=%0d mem_addr=%0d want 1 1", beats, mem_addr);
        end
    endtask

    task automatic test_incr_read();
        int beats;
        run_burst(1'b0, 32'h000, 2, 3, 1'b1, 0, -1, beats);
        n_checks++;
        if (beats !== 4 || mem_addr !== 6'd3) begin
            n_errors++;
            $display("FAIL incr_read: beats=%0d mem_addr=%0d want 4 3", beats, mem_addr);
        end
    endtask

    task automatic test_region_cross();
        int beats;
        run_burst(1'b1, 32'h0FC, 2, 1, 1'b1, 0, -1, beats);
        n_checks++;
        if (mem_addr !== 6'd63 || reg_addr !== 6'd0 || err_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL region_cross: mem_addr=%0d reg_addr=%0d err_cnt=%0d want 63 0 0",
                     mem_addr, reg_addr, err_cnt);
        end
    endtask

    task automatic test_errors();
        int beats;
        run_burst(1'b0, 32'h102, 1, 0, 1'b1, 0, -1, beats);
        n_checks++;
        if (err_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL reg_subword_err: err_cnt=%0d want 1", err_cnt);
        end
        run_burst(1'b1, 32'h003, 2, 0, 1'b1, 0, -1, beats);
        n_checks++;
        if (err_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL misalign_err: err_cnt=%0d want 2", err_cnt);
        end
    endtask

    task automatic test_stall();
        int beats;
        ready_pat = 32'b1011001;
        ready_len = 7;
        run_burst(1'b0, 32'h020, 2, 3, 1'b1, 1, -1, beats);
        n_checks++;
        if (beats !== 4) begin
            n_errors++;
            $display("FAIL stall_beats: beats=%0d want 4", beats);
        end
    endtask

    task automatic test_saturate();
        int beats;
        run_burst(1'b1, 32'h000, 3, 255, 1'b0, 0, -1, beats);
        n_checks++;
        if (err_cnt !== 8'd255 || beats !== 256) begin
            n_errors++;
            $display("FAIL err_saturate: err_cnt=%0d beats=%0d want 255 256", err_cnt, beats);
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        run_burst(1'b1, 32'h040, 2, 7, 1'b1, 0, 1, beats);
        apply_reset_and_check("reset_mid_burst");
        run_burst(1'b0, 32'h104, 2, 1, 1'b1, 0, -1, beats);
        n_checks++;
        if (beats !== 2) begin
            n_errors++;
            $display("FAIL accept_after_reset: beats=%0d want 2", beats);
        end
    endtask

    task automatic test_random();
        int          beats;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 'h23F));
            run_burst(1'($urandom % 2), a, $urandom_range(0, 4), $urandom_range(0, 7),
                      1'($urandom % 2), $urandom_range(0, 2), -1, beats);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr_read();
        test_region_cross();
        test_errors();
        test_stall();
        test_saturate();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
